// File: rtl/bitbakery_entrada_botoes.sv
// Conditions the raw active-low panel buttons for the BitBakery game logic:
// two-flop sync, per-channel stability-counter debounce, clean levels and press pulses.
module bitbakery_entrada_botoes #(
   parameter int unsigned DEBOUNCE = 4,  // must be >= 2
   parameter int unsigned CW       = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] botoes_in,
   input  logic       iniciar_in,
   output logic [6:0] botoes,
   output logic [6:0] botoes_pulso,
   output logic       iniciar,
   output logic       iniciar_nivel,
   output logic       algum_botao,
   output logic       multiplos
);

   localparam int unsigned NumCh = 8;

   logic [NumCh-1:0]         s1_q, s2_q;
   logic [NumCh-1:0]         estavel_q, estavel_d;
   logic [NumCh-1:0]         anterior_q;
   logic [NumCh-1:0][CW-1:0] cont_q, cont_d;
   logic [NumCh-1:0]         pulso;
   logic [2:0]               n_held;

   // Channel 7 is the start button; inversion makes the sync chain active-high.
   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         estavel_q  <= '0;
         anterior_q <= '0;
         cont_q     <= '0;
      end else begin
         s1_q       <= ~{iniciar_in, botoes_in};
         s2_q       <= s1_q;
         estavel_q  <= estavel_d;
         anterior_q <= estavel_q;
         cont_q     <= cont_d;
      end
   end

   // Any cycle agreeing with the stable state throws away the partial count.
   always_comb begin
      estavel_d = estavel_q;
      cont_d    = '0;
      for (int i = 0; i < NumCh; i++) begin
         if (s2_q[i] == estavel_q[i]) begin
            cont_d[i] = '0;
         end else if (cont_q[i] == CW'(DEBOUNCE - 1)) begin
            estavel_d[i] = s2_q[i];
            cont_d[i]    = '0;
         end else begin
            cont_d[i] = cont_q[i] + CW'(1);
         end
      end
   end

   always_comb begin
      n_held = '0;
      for (int i = 0; i < 7; i++) begin
         n_held = n_held + 3'(estavel_q[i]);
      end
   end

   assign pulso         = estavel_q & ~anterior_q;
   assign botoes        = estavel_q[6:0];
   assign iniciar_nivel = estavel_q[7];
   assign botoes_pulso  = pulso[6:0];
   assign iniciar       = pulso[7];
   assign algum_botao   = |pulso[6:0];
   assign multiplos     = (n_held >= 3'd2);

endmodule

// File: doc/bitbakery_entrada_botoes.md
Name: bitbakery_entrada_botoes

Overview:
- Input-conditioning stage directly upstream of the BitBakery top-level game logic.
- Takes the raw, active-low panel pushbuttons (7 game buttons plus the start button) and does three things per channel:
  - synchronizes each one to the divided game clock;
  - debounces it with a stability counter;
  - delivers clean active-high levels and single-cycle press pulses.
- Its outputs replace the bare inversions the top level applies today; the game FSMs and minigames consume them.

Parameters:
- DEBOUNCE, 4, consecutive cycles a synchronized input must differ from the debounced state before that state flips; legal range 2..2^CW-1.
- CW, 8, width of each per-channel stability counter.

Ports:
- clock  input  1  game clock; every flop samples on its rising edge.
- reset  input  1  synchronous, active-low reset.
- botoes_in  input  7  raw game buttons, active-low, asynchronous to clock.
- iniciar_in  input  1  raw start button, active-low, asynchronous to clock.
- botoes  output  7  debounced button levels, active-high (1 = held).
- botoes_pulso  output  7  one-cycle pulse on each debounced press (0→1 of botoes).
- iniciar  output  1  one-cycle pulse on debounced press of the start button.
- iniciar_nivel  output  1  debounced start-button level, active-high.
- algum_botao  output  1  one-cycle pulse when any botoes_pulso bit is set.
- multiplos  output  1  level; high while two or more botoes bits are set.

Behaviour:
- Channels:
  - 8 identical independent channels: botoes_in[6:0] map to channels 0..6, iniciar_in maps to channel 7.
  - No interaction between channels; simultaneous presses are debounced independently.
- Synchronizer: each channel has a 2-flop chain, s1 then s2. The raw input is inverted before s1, so s2 is active-high.
- Debounce logic, evaluated per channel every cycle:
  - if s2 == estavel: cont <= 0;
  - else if cont == DEBOUNCE-1: estavel <= s2 and cont <= 0;
  - else: cont <= cont+1.
  - A single cycle in which s2 matches estavel discards all accumulated count, so a glitch restarts the count.
- Latency:
  - Raw level changes and is stable before edge 0.
  - s2 reflects it after edge 1.
  - estavel flips on edge DEBOUNCE+1.
  - With DEBOUNCE=4, botoes rises after edge 5.
  - Release has the same latency.
- Outputs:
  - botoes = estavel[6:0]; iniciar_nivel = estavel[7].
- Pulses:
  - anterior is a register holding the previous estavel.
  - pulso = estavel & ~anterior. It is high in exactly the cycle estavel first reads 1, so it is simultaneous with the level rise.
  - Releases (1→0) produce no pulse.
  - A continuously held button produces exactly one pulse; there is no auto-repeat.
- algum_botao = OR of botoes_pulso[6:0]; it excludes the start button.
- multiplos = 1 when popcount(botoes) >= 2. It is combinational from registers.
- Reset (reset == 0 at a rising edge):
  - s1, s2, estavel, anterior all 0 (released); cont = 0.
  - Every output reads 0 in the following cycle.
  - Reset mid-count discards the partial count.
  - A button held through reset release re-debounces from zero and then yields one fresh pulse.
- Wrap-around: cont never exceeds DEBOUNCE-1, so it cannot wrap.
- Illegal parameter: DEBOUNCE < 2 is unsupported.

Test Plan:
- Clean press, DEBOUNCE=4: botoes_in[2] driven 1→0 and held → botoes[2]=1 after edge 5; botoes_pulso[2] and algum_botao high for exactly that one cycle, then 0 while held.
- Bounce: botoes_in[0] low for 3 cycles, high for 1, then low steadily → no change until 4 consecutive differing cycles after the glitch; exactly one botoes_pulso[0].
- Release: after the first scenario, botoes_in[2]→1 → botoes[2] falls after edge 5; no pulse on botoes_pulso[2] or algum_botao.
- Start button: iniciar_in pulled low for 10 cycles → iniciar is a single 1-cycle pulse; iniciar_nivel high for 10 cycles, delayed 5; algum_botao stays 0.
- Multiple presses: botoes_in=7'b1111010 applied in one cycle → botoes=7'b0000101; botoes_pulso bits 0 and 2 pulse together; algum_botao is one pulse; multiplos=1 until either button releases.
- Reset: reset=0 asserted mid-count and again while botoes[1]=1 → next cycle all outputs 0. With the button still held, after reset returns to 1 → botoes[1] rises 5 edges later with one new pulse.
